fetch_ctrl: RTL and testbench

- Sequences the instruction-fetch stage: owns the PC, drives the instruction-memory read handshake and produces the hold/flush controls for the IF pipeline register.
- Merges branch/jump redirects, load-use stalls and data-memory busywait into a single priority-resolved decision per cycle.
- Handles redirects that arrive while an instruction fetch is still outstanding.
- Sits between the PC mux/adder, the instruction cache and the IF pipeline register.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/sat_counter.sv | 34 +++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared front-end types and constants
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, imem handshake, IF hold/flush
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_busywait,
    output logic             imem_read,
    output logic [31:0]      imem_addr,
    input  logic             branch_jump_signal,
    input  logic [31:0]      branch_target,
    input  logic             load_use_stall,
    input  logic             dmem_busywait,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_4_out,
    output logic             if_hold,
    output logic             if_flush,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] discard_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         read_q, read_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;

    logic        done;
    logic        stall;
    logic [31:0] pc_plus4;
    logic [31:0] discard_next;
    logic        discard_inc;
    logic        stall_inc;

    assign done         = read_q & ~imem_busywait;
    assign stall        = load_use_stall | dmem_busywait;
    assign pc_plus4     = pc_q + INSTR_BYTES;
    // A redirect landing on the completing cycle of a discard is the newest one.
    assign discard_next = branch_jump_signal ? branch_target : redirect_pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        read_d        = read_q;
        redirect_pc_d = redirect_pc_q;
        if_hold       = 1'b0;
        if_flush      = 1'b0;
        fetch_valid   = 1'b0;
        discard_inc   = 1'b0;
        case (state_q)
            BOOT: begin
                if_hold = 1'b1;
                state_d = FETCH;
                read_d  = 1'b1;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (branch_jump_signal) begin
                    if_flush = 1'b1;
                    if (done) begin
                        pc_d   = branch_target;
                        addr_d = branch_target;
                    end else begin
                        // Address must stay stable until the outstanding read completes.
                        redirect_pc_d = branch_target;
                        state_d       = DISCARD;
                    end
                end else if (done && !stall) begin
                    fetch_valid = 1'b1;
                    pc_d        = pc_plus4;
                    addr_d      = pc_plus4;
                end else if (done) begin
                    if_hold = 1'b1;
                    state_d = HOLD;
                    read_d  = 1'b0;
                end else begin
                    if_hold = 1'b1;
                end
            end
            HOLD: begin
                if (branch_jump_signal) begin
                    if_flush = 1'b1;
                    pc_d     = branch_target;
                    addr_d   = branch_target;
                    state_d  = FETCH;
                    read_d   = 1'b1;
                end else begin
                    if_hold = 1'b1;
                    if (!stall) begin
                        state_d = FETCH;
                        read_d  = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if_flush = 1'b1;
                if (done) begin
                    discard_inc = 1'b1;
                    pc_d        = discard_next;
                    addr_d      = discard_next;
                    state_d     = FETCH;
                end else if (branch_jump_signal) begin
                    redirect_pc_d = branch_target;
                end
            end
            default: begin
                state_d = BOOT;
                read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            read_q        <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            read_q        <= read_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign stall_inc = if_hold & (state_q != BOOT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_discard_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (discard_inc),
        .cnt   (discard_cnt)
    );

    assign imem_read = read_q;
    assign imem_addr = addr_q;
    assign pc_out    = pc_q;
    assign pc_4_out  = pc_plus4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed vectors
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_busywait;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        branch_jump_signal;
    logic [31:0] branch_target;
    logic        load_use_stall;
    logic        dmem_busywait;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;
    logic        if_hold;
    logic        if_flush;
    logic        fetch_valid;
    logic [3:0]  stall_cnt;
    logic [3:0]  discard_cnt;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_busywait      (imem_busywait),
        .imem_read          (imem_read),
        .imem_addr          (imem_addr),
        .branch_jump_signal (branch_jump_signal),
        .branch_target      (branch_target),
        .load_use_stall     (load_use_stall),
        .dmem_busywait      (dmem_busywait),
        .pc_out             (pc_out),
        .pc_4_out           (pc_4_out),
        .if_hold            (if_hold),
        .if_flush           (if_flush),
        .fetch_valid        (fetch_valid),
        .stall_cnt          (stall_cnt),
        .discard_cnt        (discard_cnt)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic [31:0] addr;
        logic        h;
        logic        f;
        logic        v;
        logic [3:0]  sc;
        logic [3:0]  dc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string n, input logic bj, input logic [31:0] tgt,
                        input logic lus, input logic dbw, input logic ibw,
                        input logic rd, input logic [31:0] addr,
                        input logic h, input logic f, input logic v,
                        input int sc, input int dc);
        exp_t e;
        branch_jump_signal = bj;
        branch_target      = tgt;
        load_use_stall     = lus;
        dmem_busywait      = dbw;
        imem_busywait      = ibw;
        e.name = n;
        e.rd   = rd;
        e.addr = addr;
        e.h    = h;
        e.f    = f;
        e.v    = v;
        e.sc   = 4'(sc);
        e.dc   = 4'(dc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [107:0] got, want;
            e    = exp_q.pop_front();
            got  = {imem_read, imem_addr, pc_out, pc_4_out, if_hold, if_flush,
                    fetch_valid, stall_cnt, discard_cnt};
            want = {e.rd, e.addr, e.addr, e.addr + 32'd4, e.h, e.f, e.v, e.sc, e.dc};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got rd=%b addr=%h pc=%h pc4=%h h=%b f=%b v=%b sc=%0d dc=%0d | want rd=%b addr=%h pc=%h pc4=%h h=%b f=%b v=%b sc=%0d dc=%0d",
                         e.name, imem_read, imem_addr, pc_out, pc_4_out, if_hold, if_flush,
                         fetch_valid, stall_cnt, discard_cnt, e.rd, e.addr, e.addr,
                         e.addr + 32'd4, e.h, e.f, e.v, e.sc, e.dc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] t;
        int          dc;
        reset              = 1'b1;
        imem_busywait      = 1'b0;
        branch_jump_signal = 1'b0;
        branch_target      = 32'h0;
        load_use_stall     = 1'b0;
        dmem_busywait      = 1'b0;
        @(posedge clk);
        #1;

        //    name          bj tgt            lus dbw ibw  rd addr           h  f  v  sc dc
        step("rst",         0, 32'h0,         0, 0, 0,   0, 32'h0,          1, 0, 0, 0, 0);
        reset = 1'b0;
        step("boot",        0, 32'h0,         0, 0, 0,   0, 32'h0,          1, 0, 0, 0, 0);
        step("f0",          0, 32'h0,         0, 0, 0,   1, 32'h0,          0, 0, 1, 0, 0);
        step("f4",          0, 32'h0,         0, 0, 0,   1, 32'h4,          0, 0, 1, 0, 0);
        step("f8",          0, 32'h0,         0, 0, 0,   1, 32'h8,          0, 0, 1, 0, 0);
        reset = 1'b1;
        step("midrst",      0, 32'h0,         0, 0, 0,   0, 32'h0,          1, 0, 0, 0, 0);
        reset = 1'b0;
        step("boot2",       0, 32'h0,         0, 0, 0,   0, 32'h0,          1, 0, 0, 0, 0);
        step("f0b",         0, 32'h0,         0, 0, 0,   1, 32'h0,          0, 0, 1, 0, 0);
        step("f4b",         0, 32'h0,         0, 0, 0,   1, 32'h4,          0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step("busy8",   0, 32'h0,         0, 0, 1,   1, 32'h8,          1, 0, 0, i, 0);
        step("done8",       0, 32'h0,         0, 0, 0,   1, 32'h8,          0, 0, 1, 3, 0);
        step("bj_done",     1, 32'h100,       0, 0, 0,   1, 32'hC,          0, 1, 0, 3, 0);
        step("tgt100",      0, 32'h0,         0, 0, 0,   1, 32'h100,        0, 0, 1, 3, 0);
        step("bj_busy",     1, 32'h200,       0, 0, 1,   1, 32'h104,        0, 1, 0, 3, 0);
        step("disc_busy",   0, 32'h0,         0, 0, 1,   1, 32'h104,        0, 1, 0, 3, 0);
        step("disc_done",   0, 32'h0,         0, 0, 0,   1, 32'h104,        0, 1, 0, 3, 0);
        step("tgt200",      0, 32'h0,         0, 0, 0,   1, 32'h200,        0, 0, 1, 3, 1);
        step("bj2_busy",    1, 32'h280,       0, 0, 1,   1, 32'h204,        0, 1, 0, 3, 1);
        step("bj3_disc",    1, 32'h300,       0, 0, 1,   1, 32'h204,        0, 1, 0, 3, 1);
        step("disc2_done",  0, 32'h0,         0, 0, 0,   1, 32'h204,        0, 1, 0, 3, 1);
        step("tgt300",      0, 32'h0,         0, 0, 0,   1, 32'h300,        0, 0, 1, 3, 2);
        step("lus_done",    0, 32'h0,         1, 0, 0,   1, 32'h304,        1, 0, 0, 3, 2);
        step("hold_lus",    0, 32'h0,         1, 0, 0,   0, 32'h304,        1, 0, 0, 4, 2);
        step("hold_clr",    0, 32'h0,         0, 0, 0,   0, 32'h304,        1, 0, 0, 5, 2);
        step("refetch",     0, 32'h0,         0, 0, 0,   1, 32'h304,        0, 0, 1, 6, 2);
        step("bj_lus",      1, 32'h400,       1, 0, 0,   1, 32'h308,        0, 1, 0, 6, 2);
        step("dbw_done",    0, 32'h0,         0, 1, 0,   1, 32'h400,        1, 0, 0, 6, 2);
        step("hold_bj",     1, 32'hFFFF_FFFC, 0, 1, 0,   0, 32'h400,        0, 1, 0, 7, 2);
        step("wrap",        0, 32'h0,         0, 0, 0,   1, 32'hFFFF_FFFC,  0, 0, 1, 7, 2);
        for (int i = 0; i < 10; i++)
            step("sat_stall", 0, 32'h0,       0, 0, 1,   1, 32'h0,          1, 0, 0,
                 (7 + i > 15) ? 15 : 7 + i, 2);
        step("sat_s_done",  0, 32'h0,         0, 0, 0,   1, 32'h0,          0, 0, 1, 15, 2);

        a  = 32'h4;
        dc = 2;
        for (int k = 0; k < 15; k++) begin
            t = a + 32'h10;
            step("sat_d_bj",   1, t,          0, 0, 1,   1, a,              0, 1, 0, 15, dc);
            step("sat_d_done", 0, 32'h0,      0, 0, 0,   1, a,              0, 1, 0, 15, dc);
            dc = (dc + 1 > 15) ? 15 : dc + 1;
            a  = t;
        end
        step("sat_d_end",   0, 32'h0,         0, 0, 0,   1, a,              0, 0, 1, 15, 15);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
